// File: rtl/plb_dac_user_logic_pkg.sv
// Shared constants for the PLB DAC user logic.
// Covers the register map, the CTRL bit positions and the I/Q sample fields.
package plb_dac_user_logic_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_SAMPLE = 1;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DUAL  = 1;
  localparam int CTRL_FMT   = 2;

  localparam int I_LSB      = 0;
  localparam int Q_LSB      = 16;
  localparam int DAC_W      = 10;

endpackage

// File: rtl/dac_interleave.sv
// Interleaved I/Q DAC driver: divide-by-2 data clock, sample mux/register and static pins.
// Data and DCLKIO change on the same edge, so the DAC samples on the opposite clock edge.
module dac_interleave
  import plb_dac_user_logic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dual,
  input  logic             fmt,
  input  logic [DAC_W-1:0] samp_i,
  input  logic [DAC_W-1:0] samp_q,
  output logic [DAC_W-1:0] dac_data,
  output logic             dclkio,
  output logic             clkout,
  output logic             pin_md,
  output logic             clk_md,
  output logic             format,
  output logic             pwrdn,
  output logic             op_en_i,
  output logic             op_en_q
);

  logic ph;

  // ph low now means it rises on this edge, which is the I slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= 1'b0;
      dac_data <= '0;
    end else if (en) begin
      ph       <= ~ph;
      dac_data <= (!ph || !dual) ? samp_i : samp_q;
    end else begin
      ph       <= 1'b0;
    end
  end

  assign dclkio  = ph;
  assign clkout  = ~ph;
  assign pin_md  = 1'b1;
  assign clk_md  = 1'b0;
  assign format  = fmt;
  assign pwrdn   = ~en;
  assign op_en_i = en;
  assign op_en_q = en & dual;

endmodule

// File: rtl/plb_dac_user_logic.sv
// PLB DAC user logic: CTRL/SAMPLE slave registers behind the IPIF handshake,
// feeding the interleaved I/Q DAC driver.
module plb_dac_user_logic
  import plb_dac_user_logic_pkg::*;
#(
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_REG    = 2
)
(
  input  logic                        Bus2IP_Clk,
  input  logic                        Bus2IP_Reset,
  input  logic [0:C_SLV_DWIDTH-1]     Bus2IP_Data,
  input  logic [0:C_SLV_DWIDTH/8-1]   Bus2IP_BE,
  input  logic [0:C_NUM_REG-1]        Bus2IP_RdCE,
  input  logic [0:C_NUM_REG-1]        Bus2IP_WrCE,
  output logic [0:C_SLV_DWIDTH-1]     IP2Bus_Data,
  output logic                        IP2Bus_RdAck,
  output logic                        IP2Bus_WrAck,
  output logic                        IP2Bus_Error,
  output logic [0:DAC_W-1]            IP2DAC_Data,
  output logic                        IP2DAC_DCLKIO,
  output logic                        IP2DAC_Clkout,
  output logic                        IP2DAC_PinMD,
  output logic                        IP2DAC_ClkMD,
  output logic                        IP2DAC_Format,
  output logic                        IP2DAC_PWRDN,
  output logic                        IP2DAC_OpEnI,
  output logic                        IP2DAC_OpEnQ
);

  logic [C_SLV_DWIDTH-1:0] ctrl_reg;
  logic [C_SLV_DWIDTH-1:0] sample_reg;
  logic [C_SLV_DWIDTH-1:0] wdata;
  logic [C_SLV_DWIDTH-1:0] rdata;
  logic [C_SLV_DWIDTH-1:0] be_mask;
  logic                    wr_ctrl;
  logic                    wr_sample;
  logic                    rd_ctrl;
  logic                    rd_sample;

  // Bus bit 0 is the MSB, so a plain vector copy keeps LSB-numbered fields intact.
  assign wdata = Bus2IP_Data;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < C_SLV_DWIDTH/8; b++) begin
      if (Bus2IP_BE[b]) be_mask[C_SLV_DWIDTH-1-8*b -: 8] = 8'hFF;
    end
  end

  // Only one-hot chip enables select a register; 00 and 11 are no-ops.
  assign wr_ctrl   = Bus2IP_WrCE[REG_CTRL]   & ~Bus2IP_WrCE[REG_SAMPLE];
  assign wr_sample = Bus2IP_WrCE[REG_SAMPLE] & ~Bus2IP_WrCE[REG_CTRL];
  assign rd_ctrl   = Bus2IP_RdCE[REG_CTRL]   & ~Bus2IP_RdCE[REG_SAMPLE];
  assign rd_sample = Bus2IP_RdCE[REG_SAMPLE] & ~Bus2IP_RdCE[REG_CTRL];

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      ctrl_reg   <= '0;
      sample_reg <= '0;
    end else begin
      if (wr_ctrl)   ctrl_reg   <= (ctrl_reg   & ~be_mask) | (wdata & be_mask);
      if (wr_sample) sample_reg <= (sample_reg & ~be_mask) | (wdata & be_mask);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_ctrl)        rdata = ctrl_reg;
    else if (rd_sample) rdata = sample_reg;
  end

  // Handshake: every cycle a chip enable is asserted is a complete transfer;
  // the ack follows the CE combinationally in the same cycle, with no wait states.
  assign IP2Bus_Data  = rdata;
  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;

  dac_interleave u_dac_interleave (
    .clk      (Bus2IP_Clk),
    .rst      (Bus2IP_Reset),
    .en       (ctrl_reg[CTRL_EN]),
    .dual     (ctrl_reg[CTRL_DUAL]),
    .fmt      (ctrl_reg[CTRL_FMT]),
    .samp_i   (sample_reg[I_LSB +: DAC_W]),
    .samp_q   (sample_reg[Q_LSB +: DAC_W]),
    .dac_data (IP2DAC_Data),
    .dclkio   (IP2DAC_DCLKIO),
    .clkout   (IP2DAC_Clkout),
    .pin_md   (IP2DAC_PinMD),
    .clk_md   (IP2DAC_ClkMD),
    .format   (IP2DAC_Format),
    .pwrdn    (IP2DAC_PWRDN),
    .op_en_i  (IP2DAC_OpEnI),
    .op_en_q  (IP2DAC_OpEnQ)
  );

endmodule

// File: tb/tb_plb_dac_user_logic.sv
// Bench for plb_dac_user_logic: directed test-plan sequence, then random bus traffic,
// every cycle compared against a behavioural register/DAC model.
module tb_plb_dac_user_logic;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] bus_data;
  logic [0:3]  be;
  logic [0:1]  rdce;
  logic [0:1]  wrce;
  logic [0:31] ip_data;
  logic        rdack, wrack, err;
  logic [0:9]  dac_data;
  logic        dclk, clkout, pinmd, clkmd, fmt, pwrdn, openi, openq;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: register contents, cycles spent enabled, last DAC word.
  logic [31:0] m_ctrl;
  logic [31:0] m_sample;
  int          m_en_cycles;
  logic [9:0]  m_dac;
  logic        model_valid = 1'b0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  plb_dac_user_logic dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Reset  (rst),
    .Bus2IP_Data   (bus_data),
    .Bus2IP_BE     (be),
    .Bus2IP_RdCE   (rdce),
    .Bus2IP_WrCE   (wrce),
    .IP2Bus_Data   (ip_data),
    .IP2Bus_RdAck  (rdack),
    .IP2Bus_WrAck  (wrack),
    .IP2Bus_Error  (err),
    .IP2DAC_Data   (dac_data),
    .IP2DAC_DCLKIO (dclk),
    .IP2DAC_Clkout (clkout),
    .IP2DAC_PinMD  (pinmd),
    .IP2DAC_ClkMD  (clkmd),
    .IP2DAC_Format (fmt),
    .IP2DAC_PWRDN  (pwrdn),
    .IP2DAC_OpEnI  (openi),
    .IP2DAC_OpEnQ  (openq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) if (b[k]) mask[8*k +: 8] = 8'hFF;
    return (old & ~mask) | (d & mask);
  endfunction

  // Advance the model across one rising edge using pre-edge register values.
  task automatic model_edge(input logic r, input logic [1:0] w, input logic [3:0] b,
                            input logic [31:0] d);
    if (r) begin
      m_ctrl = '0; m_sample = '0; m_en_cycles = 0; m_dac = '0;
    end else begin
      if (m_ctrl[0]) begin
        m_en_cycles++;
        // Odd count: clock has just risen (I slot); even count: clock low (Q slot in dual).
        if (m_en_cycles % 2 == 1) m_dac = m_sample[9:0];
        else                      m_dac = m_ctrl[1] ? m_sample[25:16] : m_sample[9:0];
      end else begin
        m_en_cycles = 0;
      end
      if (w == 2'b10)      m_ctrl   = merge(m_ctrl, d, b);
      else if (w == 2'b01) m_sample = merge(m_sample, d, b);
    end
    exp_q.push_back(m_dac);
    model_valid = 1'b1;
  endtask

  // One bus cycle: drive, check at the falling edge, then clock the model.
  task automatic cycle(input logic r, input logic [1:0] w, input logic [1:0] rd,
                       input logic [3:0] b, input logic [31:0] d);
    logic [31:0] exp_rd;
    logic [9:0]  exp_dac;
    logic        exp_ph;
    rst = r; wrce = w; rdce = rd; be = b; bus_data = d;
    @(negedge clk);
    if (model_valid) begin
      exp_rd = (rd == 2'b10) ? m_ctrl : (rd == 2'b01) ? m_sample : 32'h0;
      check("rdata", ip_data, exp_rd);
      check("wrack", {31'b0, wrack}, {31'b0, |w});
      check("rdack", {31'b0, rdack}, {31'b0, |rd});
      check("error", {31'b0, err}, 32'h0);
      exp_ph = (m_en_cycles % 2 == 1);
      check("dclkio", {31'b0, dclk}, {31'b0, exp_ph});
      check("clkout", {31'b0, clkout}, {31'b0, ~exp_ph});
      check("pins", {26'b0, pinmd, clkmd, fmt, pwrdn, openi, openq},
            {26'b0, 1'b1, 1'b0, m_ctrl[2], ~m_ctrl[0], m_ctrl[0], m_ctrl[0] & m_ctrl[1]});
      if (exp_q.size() > 0) begin
        exp_dac = exp_q.pop_front();
        check("dac_data", {22'b0, dac_data}, {22'b0, exp_dac});
      end else begin
        check("exp_q_empty", 32'd0, 32'd1);
      end
    end
    @(posedge clk);
    model_edge(r, w, b, d);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] rd);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, rd, 4'hF, 32'h0);
  endtask

  initial begin
    rst = 1'b1; wrce = '0; rdce = '0; be = '0; bus_data = '0;
    #1;

    // Reset, then read both registers.
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'b00, 2'b00, 4'h0, 32'h0);
    check("rst_dac", {22'b0, dac_data}, 32'h0);
    check("rst_pwrdn", {31'b0, pwrdn}, 32'h1);
    cycle(1'b0, 2'b00, 2'b10, 4'h0, 32'h0);
    cycle(1'b0, 2'b00, 2'b01, 4'h0, 32'h0);

    // Single-channel: CTRL=1, SAMPLE=0x1234.
    cycle(1'b0, 2'b10, 2'b00, 4'hF, 32'h0000_0001);
    cycle(1'b0, 2'b01, 2'b00, 4'hF, 32'h0000_1234);
    idle(6, 2'b01);
    check("tp_single_i", {22'b0, dac_data}, 32'h234);
    check("tp_openq0", {31'b0, openq}, 32'h0);

    // Dual channel.
    cycle(1'b0, 2'b01, 2'b00, 4'hF, 32'h1234_0000);
    cycle(1'b0, 2'b01, 2'b00, 4'hF, 32'h1234_2345);
    cycle(1'b0, 2'b10, 2'b10, 4'hF, 32'h0000_0003);
    idle(6, 2'b10);
    check("tp_openq1", {31'b0, openq}, 32'h1);

    // Disable mid-stream, then partial byte write and re-enable.
    cycle(1'b0, 2'b10, 2'b00, 4'hF, 32'h0000_0000);
    idle(3, 2'b00);
    cycle(1'b0, 2'b01, 2'b00, 4'b0011, 32'hFFFF_FFFF);
    cycle(1'b0, 2'b00, 2'b01, 4'h0, 32'h0);
    check("tp_be_readback", ip_data, 32'h1234_FFFF);
    cycle(1'b0, 2'b10, 2'b00, 4'hF, 32'h0000_0005);
    idle(4, 2'b00);
    check("tp_i_3ff", {22'b0, dac_data}, 32'h3FF);

    // Illegal CE patterns, same-cycle read/write, reset mid-operation.
    cycle(1'b0, 2'b11, 2'b11, 4'hF, 32'hDEAD_BEEF);
    cycle(1'b0, 2'b01, 2'b01, 4'hF, 32'h0155_02AA);
    cycle(1'b0, 2'b00, 2'b01, 4'h0, 32'h0);
    cycle(1'b0, 2'b10, 2'b00, 4'hF, 32'h0000_0003);
    idle(3, 2'b00);
    cycle(1'b1, 2'b00, 2'b00, 4'h0, 32'h0);
    idle(3, 2'b10);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [1:0] w;
      logic [31:0] d;
      r = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 7))
        0, 1:    w = 2'b01;
        2:       w = 2'b10;
        3:       w = 2'b11;
        default: w = 2'b00;
      endcase
      d = $urandom;
      if (w == 2'b10 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
      cycle(r, w, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
